// File: rtl/buffer_read_sequencer_pkg.sv
// Shared types and constants for the buffer read sequencer.
// C_LOG_2 is normally provided by the surrounding codebase; a fallback is defined here.
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif

package buffer_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ         = 2'd1,
    WAIT_REQ_LOW = 2'd2
  } seq_state_e;

  localparam int D_TYPE_BUFFER = 1;

  // One extra bit so a single-PU build still has a usable id field.
  function automatic int pu_id_width(input int num_pu);
    return `C_LOG_2(num_pu) + 1;
  endfunction

endpackage

// File: rtl/buffer_read_sequencer_if.sv
// Request bus from the memory controller plus the read-buffer / PU-controller handshake.
interface buffer_read_sequencer_if #(
  parameter int RD_SIZE_W = 20,
  parameter int PU_ID_W   = 1,
  parameter int D_TYPE_W  = 2
);
  logic                 rd_req;
  logic [RD_SIZE_W-1:0] rd_req_size;
  logic [PU_ID_W-1:0]   rd_req_pu_id;
  logic [D_TYPE_W-1:0]  rd_req_d_type;
  logic                 buffer_read_req;
  logic                 buffer_read_last;
  logic                 buffer_read_empty;
  logic                 buffer_read_pop;
  logic [PU_ID_W-1:0]   pu_id;
  logic                 req_fifo_full;
  logic                 req_overflow;

  modport slave (
    input  rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type,
    input  buffer_read_req, buffer_read_empty,
    output buffer_read_last, buffer_read_pop, pu_id, req_fifo_full, req_overflow
  );

  modport master (
    output rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type,
    output buffer_read_req, buffer_read_empty,
    input  buffer_read_last, buffer_read_pop, pu_id, req_fifo_full, req_overflow
  );
endinterface

// File: rtl/buffer_read_sequencer_fifo.sv
// Pending-request queue: synchronous FIFO with first-word fall-through read data.
module buffer_read_req_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a push into a full queue is safe then.
  assign push_ok = push && (!full || pop_ok);
  assign data    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/buffer_read_sequencer.sv
// Queues buffer-bound read requests and pops `size` words per request for the PU controller.
// Optional BUFFER_READ_STATS_EN adds pop_count / req_served statistics outputs.
module buffer_read_sequencer
  import buffer_read_sequencer_pkg::*;
#(
  parameter int NUM_PU         = 1,
  parameter int D_TYPE_W       = 2,
  parameter int RD_SIZE_W      = 20,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  buffer_read_sequencer_if.slave bus
`ifdef BUFFER_READ_STATS_EN
  ,
  output logic [31:0]           pop_count,
  output logic [15:0]           req_served
`endif
);
  localparam int PU_ID_W = pu_id_width(NUM_PU);
  localparam int ENTRY_W = RD_SIZE_W + PU_ID_W;

  seq_state_e           state_q, state_d;
  logic [RD_SIZE_W-1:0] remaining_q, remaining_d;
  logic [PU_ID_W-1:0]   pu_id_q, pu_id_d;
  logic                 overflow_q, overflow_d;

  logic                 req_valid;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_data;
  logic                 pop;
  logic                 last;

  buffer_read_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({bus.rd_req_size, bus.rd_req_pu_id}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .data    (fifo_data)
  );

  // Zero-length and non-buffer requests never enter the queue.
  always_comb begin
    req_valid  = bus.rd_req
              && (bus.rd_req_d_type == D_TYPE_W'(D_TYPE_BUFFER))
              && (bus.rd_req_size != '0);
    fifo_push  = req_valid && (!fifo_full || fifo_pop);
    overflow_d = overflow_q || (req_valid && fifo_full && !fifo_pop);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pu_id_d     = pu_id_q;
    fifo_pop    = 1'b0;
    pop         = 1'b0;
    last        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.buffer_read_req && !fifo_empty) begin
          fifo_pop    = 1'b1;
          remaining_d = fifo_data[ENTRY_W-1:PU_ID_W];
          pu_id_d     = fifo_data[PU_ID_W-1:0];
          state_d     = READ;
        end
      end
      READ: begin
        pop = !bus.buffer_read_empty;
        if (pop) begin
          remaining_d = remaining_q - 1'b1;
          last        = (remaining_q == RD_SIZE_W'(1));
          if (last) begin
            state_d = WAIT_REQ_LOW;
          end
        end
      end
      // A request still held from the finished transfer must not start the next one.
      WAIT_REQ_LOW: begin
        if (!bus.buffer_read_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      pu_id_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pu_id_q     <= pu_id_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.buffer_read_pop  = pop;
  assign bus.buffer_read_last = last;
  assign bus.pu_id            = pu_id_q;
  assign bus.req_fifo_full    = fifo_full;
  assign bus.req_overflow     = overflow_q;

`ifdef BUFFER_READ_STATS_EN
  logic [31:0] pop_count_q, pop_count_d;
  logic [15:0] req_served_q, req_served_d;

  always_comb begin
    pop_count_d  = pop_count_q + 32'(pop);
    req_served_d = req_served_q + 16'(last);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_count_q  <= '0;
      req_served_q <= '0;
    end else begin
      pop_count_q  <= pop_count_d;
      req_served_q <= req_served_d;
    end
  end

  assign pop_count  = pop_count_q;
  assign req_served = req_served_q;
`endif
endmodule
